// File: rtl/spi_teensy_master.sv
// SPI mode-0 bus master for the Teensy link: one chip-select-low frame of
// FRAME_BITS bits, MSB first on MOSI, MISO captured MSB first into data_rx.
module spi_teensy_master #(
  parameter int unsigned FRAME_BITS = 512,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] data_tx,
  input  logic                  spi_miso,
  output logic                  spi_cs,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  output logic [FRAME_BITS-1:0] data_rx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  // One shared cycle counter serves every timed phase, so size it for the longest.
  localparam int unsigned MaxA   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MaxCnt = (MaxA > CS_HOLD) ? MaxA : CS_HOLD;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned BitW   = $clog2(FRAME_BITS);

  localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(FRAME_BITS - 1);

  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] data_rx_q, data_rx_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic                  done_q, done_d;

  // Next-state logic: frame sequencing, clock division and shifting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (start) begin
          tx_d    = data_tx;
          cs_d    = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (sclk_q) begin
            // Falling drive edge: sample MISO at the end of the high phase,
            // then present the next MOSI bit.
            sclk_d = 1'b0;
            rx_d   = {rx_q[FRAME_BITS-2:0], spi_miso};
            tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            if (bit_q == BitLast) begin
              bit_d   = '0;
              state_d = StHold;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d     = '0;
          cs_d      = 1'b1;
          data_rx_d = rx_q;
          done_d    = 1'b1;
          state_d   = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      done_q    <= done_d;
    end
  end

  // Outputs; MOSI is forced low outside the active part of the frame.
  always_comb begin
    spi_cs   = cs_q;
    spi_clk  = sclk_q;
    spi_mosi = ((state_q == StSetup) || (state_q == StShift)) && tx_q[FRAME_BITS-1];
    data_rx  = data_rx_q;
    busy     = (state_q != StIdle);
    done     = done_q;
  end

endmodule
